// File: rtl/uart_pkg.sv
// Shared types and constants for the shared-console UART transmitter.
// The optional idle-release feature is enabled by defining UART_ARB_TIMEOUT_EN.
package uart_pkg;

  localparam int         UART_DATA_BITS = 8;
  localparam logic [7:0] UART_NEWLINE   = 8'h0A;

  typedef enum logic {
    ARB,
    LOCK
  } arb_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer: one start bit, eight data bits LSB first, one stop bit,
// each held PULSE_WIDTH clocks, followed by at least one idle cycle.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int PULSE_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [UART_DATA_BITS-1:0] load_data,
  output logic                      ready,
  output logic                      tx
);

  localparam int            TW       = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(PULSE_WIDTH - 1);

  ser_state_e                state;
  logic [TW-1:0]             bit_tmr;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      tmr_done;

  assign tmr_done = (bit_tmr == TMR_LAST);
  assign ready    = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      bit_tmr <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (load) begin
            shreg   <= load_data;
            bit_tmr <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (tmr_done) begin
            bit_tmr <= '0;
            tx      <= shreg[0];
            state   <= S_DATA;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        S_DATA: begin
          if (tmr_done) begin
            bit_tmr <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              // shreg[1] is the next bit once the current LSB is shifted out
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        S_STOP: begin
          if (tmr_done) begin
            bit_tmr <= '0;
            state   <= S_IDLE;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Line-granular round-robin sharing of one UART tx pin among NUM_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to release a lock whose owner goes quiet for TIMEOUT clocks.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int PULSE_WIDTH = 64,
  parameter int MAX_LINE    = 128,
  parameter int TIMEOUT     = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner
);

  localparam int            OW       = $clog2(NUM_REQ);
  localparam int            CW       = $clog2(MAX_LINE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LINE - 1);
  localparam logic [OW-1:0] OWN_LAST = OW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || PULSE_WIDTH < 1 || MAX_LINE < 1 || TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arbiter: illegal parameter combination");
  end

  // Handshake rule: a byte moves only in a cycle where req_valid[i] and
  // req_ready[i] are both high; req_ready never depends on req_valid.
  arb_state_e    arb_state;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] rr_ptr;
  logic [OW-1:0] next_ptr;
  logic [OW-1:0] grant_idx;
  logic [OW-1:0] cand_idx;
  logic [CW-1:0] byte_cnt;
  logic [7:0]    cur_byte;
  logic          grant_found;
  logic          ser_ready;
  logic          handshake;
  logic          timeout_hit;
  logic          release_line;

  // Scan offsets from high to low so the nearest asserted index at/after rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand_idx = OW'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (arb_state == LOCK) req_ready[owner_q] = ser_ready;
  end

  assign cur_byte     = req_data[{owner_q, 3'b000} +: 8];
  assign handshake    = (arb_state == LOCK) && req_valid[owner_q] && ser_ready;
  assign release_line = (handshake && ((cur_byte == UART_NEWLINE) || (byte_cnt == CNT_LAST)))
                        || timeout_hit;
  assign next_ptr     = (owner_q == OWN_LAST) ? '0 : owner_q + 1'b1;
  assign busy         = (arb_state == LOCK) || !ser_ready;
  assign owner        = owner_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      arb_state <= ARB;
      owner_q   <= '0;
      rr_ptr    <= '0;
      byte_cnt  <= '0;
    end else begin
      case (arb_state)
        ARB: begin
          if (grant_found) begin
            owner_q   <= grant_idx;
            arb_state <= LOCK;
          end
        end
        LOCK: begin
          if (release_line) begin
            rr_ptr    <= next_ptr;
            byte_cnt  <= '0;
            arb_state <= ARB;
          end else if (handshake) begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        default: arb_state <= ARB;
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_cnt;

  // Counts only while the line is free to take a byte but the owner offers none.
  always_ff @(posedge clk) begin
    if (reset || arb_state != LOCK || handshake || timeout_hit) begin
      idle_cnt <= '0;
    end else if (ser_ready && !req_valid[owner_q]) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout_hit = (arb_state == LOCK) && (idle_cnt == IW'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  uart_tx_core #(
    .PULSE_WIDTH(PULSE_WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (handshake),
    .load_data(cur_byte),
    .ready    (ser_ready),
    .tx       (tx)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: grant table, directed line/reset/timeout sequences and
// random multi-requester streams checked against a line-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int         NUM_REQ  = 4;
  localparam int         PW       = 4;
  localparam int         MAX_LINE = 4;
  localparam int         TIMEOUT  = 16;
  localparam logic [7:0] NL       = 8'h0A;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx;
  logic                 busy;
  logic [1:0]           owner;

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .PULSE_WIDTH(PW),
    .MAX_LINE   (MAX_LINE),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .tx       (tx),
    .busy     (busy),
    .owner    (owner)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] src_q [NUM_REQ][$];
  logic [7:0] exp_q[$];
  logic [1:0] exp_own_q[$];
  int         hs_cnt [NUM_REQ];
  int         mdl_ptr = 0;
  bit         log_en = 0;
  logic       tx_log[$];
  logic       busy_log[$];
  bit         mon_act = 0;
  int         mon_t = 0;
  logic [7:0] mon_byte = '0;

  typedef struct {
    logic [3:0] mask;
    logic [1:0] own;
    logic       bsy;
    logic [3:0] rdy;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // ---------------- driver + monitor, one clock per call ----------------
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = (src_q[i].size() > 0);
      if (src_q[i].size() > 0) req_data[8*i +: 8] = src_q[i][0];
      else                     req_data[8*i +: 8] = 8'h00;
    end
    #1;
    check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        if (exp_own_q.size() == 0) begin
          check("hs_unexpected", 32'(i), 32'hFFFF_FFFF);
        end else begin
          check("hs_owner", 32'(i), 32'(exp_own_q.pop_front()));
        end
        void'(src_q[i].pop_front());
        hs_cnt[i]++;
      end
    end
    if (log_en) begin
      tx_log.push_back(tx);
      busy_log.push_back(busy);
    end
    // UART receiver model: sample mid-bit, LSB first
    if (!mon_act) begin
      if (tx === 1'b0) begin
        mon_act = 1;
        mon_t   = 0;
      end
    end else begin
      mon_t++;
      if (mon_t == PW/2) begin
        check("start_bit", 32'(tx), 32'd0);
      end else if (mon_t > PW && mon_t < 9*PW && ((mon_t - PW/2) % PW) == 0) begin
        mon_byte = {tx, mon_byte[7:1]};
      end else if (mon_t == 9*PW + PW/2) begin
        check("stop_bit", 32'(tx), 32'd1);
        if (exp_q.size() == 0) check("tx_byte_unexpected", 32'(mon_byte), 32'hFFFF_FFFF);
        else                   check("tx_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
        mon_act = 0;
      end
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_q[i].delete();
      hs_cnt[i] = 0;
    end
    exp_q.delete();
    exp_own_q.delete();
    mon_act = 0;
    mdl_ptr = 0;
    log_en  = 0;
    reset   = 1'b1;
    step();
    step();
    reset   = 1'b0;
  endtask

  // Line-level model: pick the first non-empty stream at/after the pointer, emit
  // until newline or MAX_LINE bytes, then move the pointer past that stream.
  task automatic model_run();
    logic [7:0] m [NUM_REQ][$];
    logic [7:0] b;
    int own;
    int cnt;
    bit found;
    bit held;
    for (int i = 0; i < NUM_REQ; i++) m[i] = src_q[i];
    held = 0;
    b    = '0;
    own  = 0;
    while (!held) begin
      found = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && m[(mdl_ptr + k) % NUM_REQ].size() > 0) begin
          found = 1;
          own   = (mdl_ptr + k) % NUM_REQ;
        end
      end
      if (!found) break;
      cnt = 0;
      do begin
        b = m[own].pop_front();
        exp_q.push_back(b);
        exp_own_q.push_back(2'(own));
        cnt++;
      end while (b != NL && cnt < MAX_LINE && m[own].size() > 0);
      if (b == NL || cnt == MAX_LINE) begin
        mdl_ptr = (own + 1) % NUM_REQ;
      end else begin
`ifdef UART_ARB_TIMEOUT_EN
        mdl_ptr = (own + 1) % NUM_REQ;
`else
        held = 1;
`endif
      end
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || mon_act) && n < budget) begin
      step();
      n++;
    end
    check({name, "_budget"}, 32'(n >= budget), 32'd0);
    check({name, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_hs(input int idx, input int target, input int budget);
    int n;
    n = 0;
    while (hs_cnt[idx] < target && n < budget) begin
      step();
      n++;
    end
    check("wait_hs_budget", 32'(n >= budget), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] fb[2];
    logic       exp_bits[$];
    int         bit_err;
    int         streak;
    int         n;
    bit         rdy3_seen;

    // reset state
    do_reset();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);

    // grant table from reset (rr_ptr = 0)
    vecs[0] = '{mask: 4'b0001, own: 2'd0, bsy: 1'b1, rdy: 4'b0001};
    vecs[1] = '{mask: 4'b0110, own: 2'd1, bsy: 1'b1, rdy: 4'b0010};
    vecs[2] = '{mask: 4'b1000, own: 2'd3, bsy: 1'b1, rdy: 4'b1000};
    vecs[3] = '{mask: 4'b1111, own: 2'd0, bsy: 1'b1, rdy: 4'b0001};
    vecs[4] = '{mask: 4'b1100, own: 2'd2, bsy: 1'b1, rdy: 4'b0100};
    vecs[5] = '{mask: 4'b0000, own: 2'd0, bsy: 1'b0, rdy: 4'b0000};
    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) if (vecs[v].mask[i]) src_q[i].push_back(NL);
      model_run();
      step();
      step();
      check("tbl_owner", 32'(owner), 32'(vecs[v].own));
      check("tbl_busy", 32'(busy), 32'(vecs[v].bsy));
      check("tbl_ready", 32'(req_ready), 32'(vecs[v].rdy));
    end

    // 0x41 then newline: exact tx waveform and busy fall
    do_reset();
    src_q[0].push_back(8'h41);
    src_q[0].push_back(NL);
    model_run();
    wait_hs(0, 1, 10);
    tx_log.delete();
    busy_log.delete();
    log_en = 1;
    repeat (82) step();
    log_en = 0;
    fb[0] = 8'h41;
    fb[1] = NL;
    exp_bits.delete();
    for (int f = 0; f < 2; f++) begin
      repeat (PW) exp_bits.push_back(1'b0);
      for (int b = 0; b < 8; b++) repeat (PW) exp_bits.push_back(fb[f][b]);
      repeat (PW + 1) exp_bits.push_back(1'b1);
    end
    bit_err = 0;
    for (int k = 0; k < 82; k++) if (tx_log[k] !== exp_bits[k]) bit_err++;
    check("frame_bit_errors", 32'(bit_err), 32'd0);
    check("hs_count_req0", 32'(hs_cnt[0]), 32'd2);
    check("busy_last_stop", 32'(busy_log[80]), 32'd1);
    check("busy_after_stop", 32'(busy_log[81]), 32'd0);
    drain("t1", 50);

    // req1 and req2 together, then grant search resumes at index 3
    do_reset();
    src_q[1].push_back(8'h31); src_q[1].push_back(8'h32); src_q[1].push_back(NL);
    src_q[2].push_back(8'h41); src_q[2].push_back(NL);
    model_run();
    drain("t2a", 400);
    check("t2_hs1", 32'(hs_cnt[1]), 32'd3);
    check("t2_hs2", 32'(hs_cnt[2]), 32'd2);
    src_q[0].push_back(8'h50); src_q[0].push_back(NL);
    src_q[3].push_back(8'h53); src_q[3].push_back(NL);
    model_run();
    step();
    step();
    check("t2_next_owner", 32'(owner), 32'd3);
    drain("t2b", 400);

    // req3 waiting must not get ready while req0 owns its line
    do_reset();
    src_q[0].push_back(8'h61); src_q[0].push_back(8'h62); src_q[0].push_back(NL);
    src_q[3].push_back(8'h7A); src_q[3].push_back(8'h7B); src_q[3].push_back(NL);
    model_run();
    rdy3_seen = 0;
    n = 0;
    while (hs_cnt[0] < 3 && n < 400) begin
      step();
      if (hs_cnt[0] < 3 && req_ready[3]) rdy3_seen = 1;
      n++;
    end
    check("t3_rdy3_during_lock", 32'(rdy3_seen), 32'd0);
    drain("t3", 400);

    // MAX_LINE forced release
    do_reset();
    for (int b = 0; b < 6; b++) src_q[0].push_back(8'h30 + 8'(b));
    src_q[1].push_back(8'h61); src_q[1].push_back(NL);
    model_run();
    drain("t4", 600);
    repeat (60) step();
`ifdef UART_ARB_TIMEOUT_EN
    check("t4_busy_released", 32'(busy), 32'd0);
`else
    check("t4_busy_held", 32'(busy), 32'd1);
    check("t4_owner_held", 32'(owner), 32'd0);
`endif

    // reset during a data bit
    do_reset();
    src_q[0].push_back(8'h55); src_q[0].push_back(NL);
    model_run();
    wait_hs(0, 1, 10);
    repeat (14) step();
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    exp_q.delete();
    exp_own_q.delete();
    mon_act = 0;
    reset   = 1'b1;
    step();
    check("t5_tx", 32'(tx), 32'd1);
    check("t5_ready", 32'(req_ready), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_owner", 32'(owner), 32'd0);
    reset   = 1'b0;
    mdl_ptr = 0;
    src_q[2].push_back(8'h3C); src_q[2].push_back(NL);
    model_run();
    drain("t5", 200);

    // owner goes quiet mid-line while req2 waits
    do_reset();
    src_q[0].push_back(8'h11);
    src_q[2].push_back(8'h22); src_q[2].push_back(NL);
    model_run();
`ifdef UART_ARB_TIMEOUT_EN
    wait_hs(0, 1, 10);
    n = 0;
    while (!req_ready[0] && n < 60) begin
      step();
      n++;
    end
    streak = 0;
    while (req_ready[0] && streak < 60) begin
      streak++;
      step();
    end
    check("t6_idle_cycles", 32'(streak), 32'(TIMEOUT + 1));
    drain("t6", 300);
    check("t6_hs2", 32'(hs_cnt[2]), 32'd2);
`else
    drain("t6", 100);
    repeat (200) step();
    check("t6_req2_never", 32'(hs_cnt[2]), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_owner", 32'(owner), 32'd0);
`endif

    // random streams, every stream ends in a newline
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
        repeat ($urandom_range(0, 2)) begin
          repeat ($urandom_range(0, 5)) src_q[i].push_back(8'($urandom_range(0, 255)));
          src_q[i].push_back(NL);
        end
      end
      model_run();
      drain("rand", 3000);
      repeat (3) step();
      check("rand_idle", 32'(busy), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
